// File: rtl/score_display_scanner.sv
// Score display feeder: sequential binary-to-BCD conversion (double dabble)
// followed by a free-running 4-digit multiplexed scan with leading-zero blanking.
module score_display_scanner #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  bcd,
  output logic [3:0]  anode
);

  localparam int unsigned VAL_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VAL_W - 1);
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                     state_q, state_d;
  logic [SR_W-1:0]            sr_q, sr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic [3:0][DIG_W-1:0]      digit_q, digit_d;
  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [3:0]                 blank;

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[VAL_W + DIG_W*i +: DIG_W] >= DIG_W'(5))
        t[VAL_W + DIG_W*i +: DIG_W] = t[VAL_W + DIG_W*i +: DIG_W] + DIG_W'(3);
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Converter next state: capture on load in IDLE, 14 shifts, publish digits on the last.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    digit_d = digit_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = {BCD_W'(0), (value > MAX_VAL) ? MAX_VAL : value};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = dd_step(sr_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          digit_d = sr_d[SR_W-1:VAL_W];
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan next state: prescaler wraps at REFRESH_DIV and advances the digit index.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_TC) begin
      pre_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // State registers; reset aborts any conversion and clears the shown digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      digit_q <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      digit_q <= digit_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  // Leading-zero blanking mask; the ones digit is always shown.
  always_comb begin
    blank    = '0;
    blank[3] = BLANK_LEADING && (digit_q[3] == '0);
    blank[2] = blank[3] && (digit_q[2] == '0);
    blank[1] = blank[2] && (digit_q[1] == '0);
  end

  // Display drive decoded from registered digit/index state.
  always_comb begin
    bcd   = digit_q[idx_q];
    anode = blank[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with a short refresh divider.
module tb_score_display_scanner;

  logic        clk;
  logic        reset;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  bcd;
  logic [3:0]  anode;

  int n_vec;
  int n_err;

  score_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .bcd   (bcd),
    .anode (anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports a miscompare.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Load a value, optionally re-pulse load at busy cycle late_cyc, and check busy length.
  task automatic run_load(input logic [13:0] v, input int late_cyc, input logic [13:0] late_v);
    int n;
    value = v;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == late_cyc) begin
        value = late_v;
        load  = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
    end
    check_eq("busy_len", 32'(n), 32'd14);
    @(negedge clk);
    check_eq("idle_after", 32'(busy), 32'd0);
  endtask

  // Align to the first cycle of slot 0, then check each slot's bcd/anode.
  task automatic scan_check(input string tag, input logic [15:0] exp_d, input logic [15:0] exp_a);
    int t;
    t = 0;
    while (anode == 4'b1110 && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (anode != 4'b1110 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check_eq({tag, "_sync"}, 32'(anode), 32'he);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_bcd%0d", tag, i), 32'(bcd), 32'(exp_d[4*i +: 4]));
      check_eq($sformatf("%s_an%0d", tag, i), 32'(anode), 32'(exp_a[4*i +: 4]));
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    value = '0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'd0);
    check_eq("rst_anode", 32'(anode), 32'he);
    reset = 1'b0;

    // Slot 0 lasts 4 clocks, then blanked digit 1.
    repeat (3) @(negedge clk);
    check_eq("slot0_end", 32'(anode), 32'he);
    @(negedge clk);
    check_eq("slot1_blank", 32'(anode), 32'hf);
    check_eq("slot1_bcd", 32'(bcd), 32'd0);

    run_load(14'd1234, 0, 14'd0);
    scan_check("v1234", 16'h1234, 16'h7bde);

    run_load(14'd7, 0, 14'd0);
    scan_check("v7", 16'h0007, 16'hfffe);

    run_load(14'd405, 0, 14'd0);
    scan_check("v405", 16'h0405, 16'hfbde);

    run_load(14'd12000, 0, 14'd0);
    scan_check("v12000", 16'h9999, 16'h7bde);

    run_load(14'd9999, 0, 14'd0);
    scan_check("v9999", 16'h9999, 16'h7bde);

    run_load(14'd10000, 0, 14'd0);
    scan_check("v10000", 16'h9999, 16'h7bde);

    // Load while busy is dropped.
    run_load(14'd1234, 5, 14'd5678);
    scan_check("drop_mid", 16'h1234, 16'h7bde);

    // Load coincident with the final shift edge is dropped.
    run_load(14'd4321, 14, 14'd5678);
    scan_check("drop_last", 16'h4321, 16'h7bde);

    run_load(14'd5678, 0, 14'd0);
    scan_check("v5678", 16'h5678, 16'h7bde);

    run_load(14'd0, 0, 14'd0);
    scan_check("v0", 16'h0000, 16'hfffe);

    // Reset mid-conversion aborts and clears the display.
    run_load(14'd4321, 0, 14'd0);
    scan_check("pre_rst", 16'h4321, 16'h7bde);
    value = 14'd9876;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 7) begin
      n++;
      if (n < 7) @(negedge clk);
    end
    check_eq("busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_anode", 32'(anode), 32'he);
    check_eq("mid_rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_bcd%0d", i), 32'(bcd), 32'd0);
    end
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    scan_check("post_rst", 16'h0000, 16'hfffe);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
